// File: rtl/pixel_readout_sequencer.sv
// Pixel readout sequencer with a single-slope ADC back-end.
// Walks N_PIX pixels through reset / integrate / sample / convert, counts the
// comparator trip time and hands each result out over a valid/ready handshake.
module pixel_readout_sequencer #(
  parameter int N_PIX = 12,
  parameter int CNT_W = 10,
  parameter int T_W   = 8,
  localparam int PIX_W = $clog2(N_PIX)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic [T_W-1:0]   t_rst,
  input  logic [T_W-1:0]   t_int,
  input  logic [T_W-1:0]   t_sh,
  input  logic [CNT_W-1:0] ramp_max,
  input  logic             cmp_in,
  output logic [N_PIX-1:0] pix_sel,
  output logic             sh_rst,
  output logic             sw1,
  output logic             sh,
  output logic             sw2,
  output logic             sh_cmp,
  output logic             busy,
  output logic [CNT_W-1:0] data,
  output logic [PIX_W-1:0] data_pix,
  output logic             overflow,
  output logic             data_valid,
  input  logic             data_ready
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_INT    = 3'd2,
    S_SAMPLE = 3'd3,
    S_CONV   = 3'd4,
    S_OUT    = 3'd5
  } state_t;

  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(N_PIX - 1);

  state_t             state;
  logic [T_W-1:0]     ph_cnt;
  logic [CNT_W-1:0]   adc_cnt;
  logic [PIX_W-1:0]   pix;
  logic [PIX_W-1:0]   pix_nxt;
  logic [T_W-1:0]     cfg_t_rst;
  logic [T_W-1:0]     cfg_t_int;
  logic [T_W-1:0]     cfg_t_sh;
  logic [CNT_W-1:0]   cfg_ramp_max;
  logic               cfg_cont;
  logic               cmp_m;
  logic               cmp_s;

  assign pix_nxt = pix + 1'b1;

  function automatic logic [N_PIX-1:0] onehot(input logic [PIX_W-1:0] idx);
    logic [N_PIX-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Strobe pattern {sh_rst, sw1, sh, sw2, sh_cmp} for the state being entered.
  function automatic logic [4:0] strobes(input state_t s);
    logic [4:0] v;
    v = '0;
    case (s)
      S_RST:    v = 5'b10000;
      S_INT:    v = 5'b01000;
      S_SAMPLE: v = 5'b00100;
      S_CONV:   v = 5'b00011;
      default:  v = 5'b00000;
    endcase
    return v;
  endfunction

  // Two-flop synchroniser for the asynchronous comparator output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_m <= 1'b0;
      cmp_s <= 1'b0;
    end else begin
      cmp_m <= cmp_in;
      cmp_s <= cmp_m;
    end
  end

  // Sequencer FSM; every output is registered from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ph_cnt       <= '0;
      adc_cnt      <= '0;
      pix          <= '0;
      cfg_t_rst    <= '0;
      cfg_t_int    <= '0;
      cfg_t_sh     <= '0;
      cfg_ramp_max <= '0;
      cfg_cont     <= 1'b0;
      pix_sel      <= '0;
      {sh_rst, sw1, sh, sw2, sh_cmp} <= 5'b00000;
      busy         <= 1'b0;
      data         <= '0;
      data_pix     <= '0;
      overflow     <= 1'b0;
      data_valid   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_RST;
            ph_cnt       <= '0;
            pix          <= '0;
            cfg_t_rst    <= t_rst;
            cfg_t_int    <= t_int;
            cfg_t_sh     <= t_sh;
            cfg_ramp_max <= ramp_max;
            cfg_cont     <= continuous;
            pix_sel      <= onehot('0);
            busy         <= 1'b1;
            {sh_rst, sw1, sh, sw2, sh_cmp} <= strobes(S_RST);
          end
        end
        S_RST: begin
          if (ph_cnt == cfg_t_rst) begin
            state  <= S_INT;
            ph_cnt <= '0;
            {sh_rst, sw1, sh, sw2, sh_cmp} <= strobes(S_INT);
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        S_INT: begin
          if (ph_cnt == cfg_t_int) begin
            state  <= S_SAMPLE;
            ph_cnt <= '0;
            {sh_rst, sw1, sh, sw2, sh_cmp} <= strobes(S_SAMPLE);
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        S_SAMPLE: begin
          if (ph_cnt == cfg_t_sh) begin
            state   <= S_CONV;
            ph_cnt  <= '0;
            adc_cnt <= '0;
            {sh_rst, sw1, sh, sw2, sh_cmp} <= strobes(S_CONV);
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        S_CONV: begin
          // A trip wins over the timeout when both happen on the same count.
          if (cmp_s) begin
            state      <= S_OUT;
            data       <= adc_cnt;
            overflow   <= 1'b0;
            data_pix   <= pix;
            data_valid <= 1'b1;
            {sh_rst, sw1, sh, sw2, sh_cmp} <= strobes(S_OUT);
          end else if (adc_cnt == cfg_ramp_max) begin
            state      <= S_OUT;
            data       <= cfg_ramp_max;
            overflow   <= 1'b1;
            data_pix   <= pix;
            data_valid <= 1'b1;
            {sh_rst, sw1, sh, sw2, sh_cmp} <= strobes(S_OUT);
          end else begin
            adc_cnt <= adc_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (data_ready) begin
            data_valid <= 1'b0;
            if (pix != LAST_PIX) begin
              state   <= S_RST;
              ph_cnt  <= '0;
              pix     <= pix_nxt;
              pix_sel <= onehot(pix_nxt);
              {sh_rst, sw1, sh, sw2, sh_cmp} <= strobes(S_RST);
            end else if (cfg_cont) begin
              // Frame wrap: configuration is picked up afresh for the new frame.
              state        <= S_RST;
              ph_cnt       <= '0;
              pix          <= '0;
              pix_sel      <= onehot('0);
              cfg_t_rst    <= t_rst;
              cfg_t_int    <= t_int;
              cfg_t_sh     <= t_sh;
              cfg_ramp_max <= ramp_max;
              cfg_cont     <= continuous;
              {sh_rst, sw1, sh, sw2, sh_cmp} <= strobes(S_RST);
            end else begin
              state   <= S_IDLE;
              pix     <= '0;
              pix_sel <= '0;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          pix_sel <= '0;
          busy    <= 1'b0;
          {sh_rst, sw1, sh, sw2, sh_cmp} <= 5'b00000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_readout_sequencer.sv
// Testbench for pixel_readout_sequencer: directed scenarios with randomized
// comparator timing, backpressure and mid-frame input noise, checked every
// cycle against a phase-timeline reference model.
module tb_pixel_readout_sequencer;
  localparam int NP = 12;
  localparam int CW = 10;
  localparam int TW = 8;
  localparam int PW = $clog2(NP);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic [TW-1:0] t_rst = '0;
  logic [TW-1:0] t_int = '0;
  logic [TW-1:0] t_sh = '0;
  logic [CW-1:0] ramp_max = '0;
  logic          cmp_in = 1'b0;
  logic          data_ready = 1'b0;
  logic [NP-1:0] pix_sel;
  logic          sh_rst, sw1, sh, sw2, sh_cmp, busy, overflow, data_valid;
  logic [CW-1:0] data;
  logic [PW-1:0] data_pix;

  int errors = 0;
  int checks = 0;

  // Scenario knobs for the reference model.
  int nom_tr, nom_ti, nom_ts, nom_rm;
  bit nom_cont;
  bit scramble;
  int rise_mode, rise_fix, back_mode, back_fix;
  int mod_at = -1;
  int mod_ti;
  bit mod_cont;
  int pix_count = 0;

  always #5 clk = ~clk;

  pixel_readout_sequencer #(.N_PIX(NP), .CNT_W(CW), .T_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .t_rst(t_rst), .t_int(t_int), .t_sh(t_sh), .ramp_max(ramp_max),
    .cmp_in(cmp_in), .pix_sel(pix_sel), .sh_rst(sh_rst), .sw1(sw1), .sh(sh),
    .sw2(sw2), .sh_cmp(sh_cmp), .busy(busy), .data(data), .data_pix(data_pix),
    .overflow(overflow), .data_valid(data_valid), .data_ready(data_ready)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: no summary within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix_sel"}, 32'(pix_sel), 32'd0);
    chk({tag, "_strobes"}, 32'({sh_rst, sw1, sh, sw2, sh_cmp}), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_data"}, 32'(data), 32'd0);
    chk({tag, "_data_pix"}, 32'(data_pix), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_data_valid"}, 32'(data_valid), 32'd0);
  endtask

  // ph: 0 idle, 1 reset, 2 integrate, 3 sample, 4 convert, 5 output.
  task automatic expect_cycle(input int ph, input int p, input int d, input int ov);
    logic [31:0] sel;
    sel = (ph == 0) ? 32'd0 : (32'd1 << p);
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("pix_sel", 32'(pix_sel), sel);
    chk("strobes", 32'({sh_rst, sw1, sh, sw2, sh_cmp}),
        32'({ph == 1, ph == 2, ph == 3, ph == 4, ph == 4}));
    chk("data_valid", 32'(data_valid), 32'(ph == 5));
    if (ph == 5) begin
      chk("data", 32'(data), 32'(d));
      chk("data_pix", 32'(data_pix), 32'(p));
      chk("overflow", 32'(overflow), 32'(ov));
    end
  endtask

  // Configuration inputs during a frame: noise unless this is the cycle on
  // which a wrap could latch them.
  task automatic drive_cfg(input bit latch_cycle);
    if (scramble && !latch_cycle) begin
      t_rst      = TW'($urandom);
      t_int      = TW'($urandom);
      t_sh       = TW'($urandom);
      ramp_max   = CW'($urandom);
      continuous = 1'($urandom);
    end else begin
      t_rst      = TW'(nom_tr);
      t_int      = TW'(nom_ti);
      t_sh       = TW'(nom_ts);
      ramp_max   = CW'(nom_rm);
      continuous = nom_cont;
    end
    start = scramble ? 1'($urandom) : 1'b0;
  endtask

  // Reference model: each pixel is a timeline of phase lengths; the result is
  // the first count at which the synchronised comparator (cmp_in delayed two
  // cycles) is seen high, capped at ramp_max.
  task automatic run_frames();
    int tr, ti, ts, rm, p, r, b, c0, k, d, ov, clen, ph;
    bit cont;
    t_rst = TW'(nom_tr); t_int = TW'(nom_ti); t_sh = TW'(nom_ts);
    ramp_max = CW'(nom_rm); continuous = nom_cont;
    cmp_in = 1'b0; data_ready = 1'b0; start = 1'b1;
    expect_cycle(0, 0, 0, 0);
    tick();
    start = 1'b0;
    tr = nom_tr; ti = nom_ti; ts = nom_ts; rm = nom_rm; cont = nom_cont;
    p = 0;
    forever begin
      if (pix_count == mod_at) begin
        nom_ti = mod_ti;
        nom_cont = mod_cont;
      end
      pix_count++;
      case (rise_mode)
        0:       r = rise_fix;
        1:       r = int'($urandom_range(60, 0));
        2:       r = 1 << 20;
        default: r = -100;
      endcase
      if (back_mode == 0) b = back_fix;
      else b = (p == 3) ? 10 : int'($urandom_range(3, 0));
      c0 = tr + ti + ts + 3;
      k = (r + 2 > 0) ? r + 2 : 0;
      if (k > rm) begin d = rm; ov = 1; clen = rm + 1; end
      else begin d = k; ov = 0; clen = k + 1; end
      for (int j = 0; j < c0 + clen + b + 1; j++) begin
        if (j <= tr) ph = 1;
        else if (j <= tr + ti + 1) ph = 2;
        else if (j < c0) ph = 3;
        else if (j < c0 + clen) ph = 4;
        else ph = 5;
        expect_cycle(ph, p, d, ov);
        cmp_in = ((j - c0) >= r);
        if (ph == 5) data_ready = (j == c0 + clen + b);
        else data_ready = 1'($urandom);
        drive_cfg((j == c0 + clen + b) && (p == NP - 1));
        tick();
      end
      if (p < NP - 1) begin
        p++;
      end else if (cont) begin
        p = 0;
        tr = nom_tr; ti = nom_ti; ts = nom_ts; rm = nom_rm; cont = nom_cont;
      end else begin
        expect_cycle(0, 0, 0, 0);
        start = 1'b0;
        scramble = 1'b0;
        drive_cfg(1'b1);
        tick();
        expect_cycle(0, 0, 0, 0);
        return;
      end
    end
  endtask

  initial begin
    // Power-on reset and idle
    tick();
    tick();
    chk_all_zero("por");
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      expect_cycle(0, 0, 0, 0);
      tick();
    end

    // Asynchronous reset in the middle of a conversion
    t_rst = '0; t_int = '0; t_sh = '0; ramp_max = CW'(1023); continuous = 1'b0;
    cmp_in = 1'b0; data_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_reset_sw2", 32'(sw2), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    tick();
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      expect_cycle(0, 0, 0, 0);
      tick();
    end

    // Nominal frame: comparator timed for a result of 38 on every pixel
    nom_tr = 2; nom_ti = 5; nom_ts = 1; nom_rm = 1023; nom_cont = 1'b0;
    scramble = 1'b0; rise_mode = 0; rise_fix = 36; back_mode = 0; back_fix = 0;
    run_frames();

    // Timeout: comparator never trips, ramp_max = 15
    nom_rm = 15; rise_mode = 2;
    run_frames();

    // Backpressure and mid-frame input noise with random trip times
    nom_tr = int'($urandom_range(7, 0)); nom_ti = int'($urandom_range(7, 0));
    nom_ts = int'($urandom_range(7, 0)); nom_rm = int'($urandom_range(80, 20));
    scramble = 1'b1; rise_mode = 1; back_mode = 1;
    run_frames();

    // Continuous mode: t_int reprogrammed and continuous dropped mid-frame
    nom_tr = 1; nom_ti = 2; nom_ts = 0; nom_rm = 40; nom_cont = 1'b1;
    scramble = 1'b0; rise_mode = 1; back_mode = 0; back_fix = 0;
    mod_at = pix_count + 5; mod_ti = 6; mod_cont = 1'b0;
    run_frames();
    mod_at = -1;

    // Boundaries: zero-length phases, comparator already high, start while busy
    nom_tr = 0; nom_ti = 0; nom_ts = 0; nom_rm = 1023; nom_cont = 1'b0;
    scramble = 1'b1; rise_mode = 3; back_mode = 0; back_fix = 0;
    run_frames();
    nom_rm = 0; rise_mode = 2;
    run_frames();
    nom_rm = 0; rise_mode = 3; back_mode = 1;
    run_frames();

    // Random frames
    for (int f = 0; f < 3; f++) begin
      nom_tr = int'($urandom_range(6, 0)); nom_ti = int'($urandom_range(6, 0));
      nom_ts = int'($urandom_range(6, 0)); nom_rm = int'($urandom_range(70, 0));
      nom_cont = 1'b0; scramble = 1'b1; rise_mode = 1; back_mode = 1;
      run_frames();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
